rob_commit_regfile: RTL and testbench

// - Architectural register file with per-register rename tags; the consuming end of the ROB commit/dispatch interface.
// - Dispatch renames rd to the ROB tag. Commit writes rdest data back and clears busy.
// - Supplies source operands to the reservation stations: value when ready, producing ROB tag when busy.
// - Flush rebuilds rename state from surviving ROB entries.

---
 rtl/rob_commit_regfile.sv | 142 ++++++++++++++
 tb/tb_rob_commit_regfile.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rob_commit_regfile.sv
// rtl/rob_commit_regfile.sv - renamed architectural register file, the commit/flush end of the ROB interface
// Define BYPASS_EN to return broadcast results for busy operands in the same cycle.
module rob_commit_regfile #(
  parameter int width = 32,
  parameter int size  = 8,
  parameter int nregs = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reg_ld_instr,
  input  logic [4:0]                      rd_dispatch,
  input  logic [3:0]                      rd_tag,
  input  logic [4:0]                      rs1_idx,
  input  logic [4:0]                      rs2_idx,
  input  logic [size-1:0][width+4:0]      rdest,
  input  logic [size-1:0][4:0]            rd_bus,
  input  logic [size-1:0]                 rd_wr_bus,
  input  logic [3:0]                      rob_front_tag,
  input  logic                            rob_empty,
  input  logic [size-1:0][width+4:0]      rob_broadcast_bus,
  input  logic                            flush,
  input  logic [3:0]                      flush_tag,
  output logic [width+4:0]                rs1_o,
  output logic [width+4:0]                rs2_o
);

  localparam int TW = 4;
  localparam int SW = $clog2(size);
  localparam int RW = 5;

  logic [width-1:0] r_val [nregs];
  logic [nregs-1:0] r_busy;
  logic [TW-1:0]    r_tag [nregs];

  logic [width-1:0] w_val_n [nregs];
  logic [nregs-1:0] w_busy_n;
  logic [TW-1:0]    w_tag_n [nregs];
  logic [size-1:0]  w_commit;
  logic             w_unused;

  assign w_unused = ^{rdest, rob_broadcast_bus};

  always_comb begin
    w_commit = '0;
    for (int i = 0; i < size; i++) begin
      w_commit[SW'(i)] = rdest[SW'(i)][width] & rd_wr_bus[SW'(i)] & (rd_bus[SW'(i)] != 5'd0);
    end
  end

  // Commits are applied oldest-first so the youngest write to a register lands last.
  always_comb begin
    int       slot;
    int       age;
    int       s;
    int       len;
    logic     win_empty;
    logic     found;
    logic [TW-1:0] sel;
    w_val_n   = r_val;
    w_busy_n  = r_busy;
    w_tag_n   = r_tag;
    slot      = 0;
    age       = 0;
    s         = 0;
    found     = 1'b0;
    sel       = '0;
    len       = (int'(flush_tag) - int'(rob_front_tag) + size) % size;
    win_empty = rob_empty || (len == 0);
    for (int k = 0; k < size; k++) begin
      slot = (int'(rob_front_tag) + k) % size;
      if (w_commit[SW'(slot)]) begin
        w_val_n[rd_bus[SW'(slot)]] = rdest[SW'(slot)][width-1:0];
        if (int'(r_tag[rd_bus[SW'(slot)]]) == slot) begin
          w_busy_n[rd_bus[SW'(slot)]] = 1'b0;
        end
      end
    end
    if (flush) begin
      for (int r = 1; r < nregs; r++) begin
        age = (int'(r_tag[RW'(r)]) - int'(rob_front_tag) + size) % size;
        if (w_busy_n[RW'(r)] && (win_empty || age >= len)) begin
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < size; k++) begin
            s = (int'(rob_front_tag) + k) % size;
            if (!win_empty && k < len && rd_wr_bus[SW'(s)] &&
                rd_bus[SW'(s)] == RW'(r) && !rdest[SW'(s)][width]) begin
              found = 1'b1;
              sel   = TW'(s);
            end
          end
          if (found) w_tag_n[RW'(r)] = sel;
          else       w_busy_n[RW'(r)] = 1'b0;
        end
      end
    end else if (reg_ld_instr && rd_dispatch != 5'd0) begin
      w_busy_n[rd_dispatch] = 1'b1;
      w_tag_n[rd_dispatch]  = rd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int r = 0; r < nregs; r++) begin
        r_val[RW'(r)] <= '0;
        r_tag[RW'(r)] <= '0;
      end
    end else begin
      r_busy <= w_busy_n;
      for (int r = 0; r < nregs; r++) begin
        r_val[RW'(r)] <= w_val_n[RW'(r)];
        r_tag[RW'(r)] <= w_tag_n[RW'(r)];
      end
    end
  end

  function automatic logic [width+4:0] f_read(input logic [RW-1:0] idx);
    logic [width+4:0] v;
    v = {{TW{1'b0}}, 1'b1, r_val[idx]};
    if (rst || idx == '0) begin
      v = {{TW{1'b0}}, 1'b1, {width{1'b0}}};
    end else if (r_busy[idx]) begin
`ifdef BYPASS_EN
      if (rob_broadcast_bus[r_tag[idx][SW-1:0]][width]) begin
        v = {r_tag[idx], 1'b1, rob_broadcast_bus[r_tag[idx][SW-1:0]][width-1:0]};
      end else begin
        v = {r_tag[idx], 1'b0, {width{1'b0}}};
      end
`else
      v = {r_tag[idx], 1'b0, {width{1'b0}}};
`endif
    end
    return v;
  endfunction

  always_comb begin
    rs1_o = f_read(rs1_idx);
    rs2_o = f_read(rs2_idx);
  end

endmodule

// File: tb/tb_rob_commit_regfile.sv
// tb/tb_rob_commit_regfile.sv - directed scoreboard bench for rob_commit_regfile
module tb_rob_commit_regfile;

  logic             clk = 1'b0;
  logic             rst;
  logic             reg_ld_instr;
  logic [4:0]       rd_dispatch;
  logic [3:0]       rd_tag;
  logic [4:0]       rs1_idx;
  logic [4:0]       rs2_idx;
  logic [7:0][36:0] rdest;
  logic [7:0][4:0]  rd_bus;
  logic [7:0]       rd_wr_bus;
  logic [3:0]       rob_front_tag;
  logic             rob_empty;
  logic [7:0][36:0] rob_broadcast_bus;
  logic             flush;
  logic [3:0]       flush_tag;
  logic [36:0]      rs1_o;
  logic [36:0]      rs2_o;

  typedef struct {
    string       nm;
    int          port;
    logic [36:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  rob_commit_regfile dut (
    .clk(clk), .rst(rst), .reg_ld_instr(reg_ld_instr), .rd_dispatch(rd_dispatch),
    .rd_tag(rd_tag), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rdest(rdest),
    .rd_bus(rd_bus), .rd_wr_bus(rd_wr_bus), .rob_front_tag(rob_front_tag),
    .rob_empty(rob_empty), .rob_broadcast_bus(rob_broadcast_bus), .flush(flush),
    .flush_tag(flush_tag), .rs1_o(rs1_o), .rs2_o(rs2_o)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] sal(input logic [3:0] t, input logic r, input logic [31:0] d);
    return {t, r, d};
  endfunction

  task automatic push(input string nm, input int port, input logic [36:0] e);
    exp_t x;
    x.nm = nm;
    x.port = port;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic idle();
    reg_ld_instr = 1'b0; rd_dispatch = '0; rd_tag = '0;
    rs1_idx = '0; rs2_idx = '0; rdest = '0; rd_bus = '0; rd_wr_bus = '0;
    rob_front_tag = '0; rob_empty = 1'b0; rob_broadcast_bus = '0;
    flush = 1'b0; flush_tag = '0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [3:0] t);
    reg_ld_instr = 1'b1; rd_dispatch = rd; rd_tag = t;
  endtask

  task automatic commit(input int slot, input logic [4:0] rd, input logic [31:0] d);
    rdest[slot] = sal(4'(slot), 1'b1, d);
    rd_bus[slot] = rd;
    rd_wr_bus[slot] = 1'b1;
  endtask

  task automatic tick();
    exp_t e;
    logic [36:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = (e.port == 1) ? rs1_o : rs2_o;
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.nm, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(); rs1_idx = 5; push("rst_x5", 1, sal(0, 1, 0)); push("rst_x0", 2, sal(0, 1, 0)); tick();
    idle(); tick();
    rst = 1'b0;
    idle(); rs1_idx = 5; push("x5_after_rst", 1, sal(0, 1, 0)); push("x0_after_rst", 2, sal(0, 1, 0)); tick();

    idle(); disp(3, 2); rs1_idx = 3; push("disp_own_src", 1, sal(0, 1, 0)); tick();
    idle(); rs1_idx = 3; push("x3_renamed", 1, sal(2, 0, 0));
    commit(2, 3, 32'hDEAD); rob_front_tag = 2; tick();
    idle(); rs1_idx = 3; push("x3_committed", 1, sal(0, 1, 32'hDEAD)); tick();

    idle(); disp(4, 1); tick();
    idle(); disp(4, 3); tick();
    idle(); rs2_idx = 4; push("x4_tag3", 2, sal(3, 0, 0)); commit(1, 4, 32'h11); rob_front_tag = 1; tick();
    idle(); rs2_idx = 4; push("x4_still_busy", 2, sal(3, 0, 0)); flush = 1'b1; rob_empty = 1'b1; tick();
    idle(); rs2_idx = 4; push("x4_val_11", 2, sal(0, 1, 32'h11)); commit(3, 4, 32'h33); rob_front_tag = 3; tick();
    idle(); rs2_idx = 4; push("x4_val_33", 2, sal(0, 1, 32'h33)); tick();

    idle(); disp(8, 0); tick();
    idle(); rs1_idx = 8; push("x8_tag0", 1, sal(0, 0, 0)); commit(0, 8, 32'h88); disp(8, 4); tick();
    idle(); rs1_idx = 8; push("x8_redisp_wins", 1, sal(4, 0, 0)); commit(4, 8, 32'h99); rob_front_tag = 4; tick();
    idle(); rs1_idx = 8; push("x8_val_99", 1, sal(0, 1, 32'h99)); tick();

    idle(); disp(7, 6); tick();
    idle(); disp(7, 1); tick();
    idle(); rs1_idx = 7; push("x7_tag1", 1, sal(1, 0, 0));
    commit(6, 7, 32'h66); commit(1, 7, 32'h71); rob_front_tag = 5; tick();
    idle(); rs1_idx = 7; push("x7_wrap_youngest", 1, sal(0, 1, 32'h71)); tick();
    idle(); disp(7, 5); tick();
    idle(); commit(2, 7, 32'h72); commit(5, 7, 32'h75); rob_front_tag = 0; tick();
    idle(); rs1_idx = 7; push("x7_linear_youngest", 1, sal(0, 1, 32'h75)); tick();

    idle(); disp(0, 5); commit(3, 0, 32'hBAD); rob_front_tag = 3; tick();
    idle(); push("x0_rs1", 1, sal(0, 1, 0)); push("x0_rs2", 2, sal(0, 1, 0)); tick();

    idle(); disp(10, 0); tick();
    idle(); commit(0, 10, 32'hA0); tick();
    idle(); disp(9, 2); rs2_idx = 10; push("x10_val_a0", 2, sal(0, 1, 32'hA0)); tick();
    idle(); disp(9, 5); tick();
    idle(); disp(10, 6); tick();
    idle(); rs1_idx = 9; rs2_idx = 10;
    push("x9_pre_flush", 1, sal(5, 0, 0)); push("x10_pre_flush", 2, sal(6, 0, 0));
    flush = 1'b1; flush_tag = 2'd0 + 4; rob_front_tag = 2; disp(11, 7);
    rd_bus[2] = 9; rd_wr_bus[2] = 1'b1; rd_bus[5] = 9; rd_wr_bus[5] = 1'b1;
    rd_bus[6] = 10; rd_wr_bus[6] = 1'b1; tick();
    idle(); rs1_idx = 9; rs2_idx = 10;
    push("x9_rebuilt", 1, sal(2, 0, 0)); push("x10_restored", 2, sal(0, 1, 32'hA0)); tick();
    idle(); rs1_idx = 11; push("x11_flush_disp_ignored", 1, sal(0, 1, 0)); tick();

    idle(); flush = 1'b1; rob_front_tag = 3; flush_tag = 3; rd_bus[3] = 9; rd_wr_bus[3] = 1'b1; tick();
    idle(); rs1_idx = 9; push("x9_no_survivors", 1, sal(0, 1, 0)); tick();

    idle(); disp(13, 7); tick();
    idle(); disp(13, 2); tick();
    idle(); rs1_idx = 13; push("x13_pre_flush", 1, sal(2, 0, 0));
    flush = 1'b1; rob_front_tag = 6; flush_tag = 1;
    rd_bus[7] = 13; rd_wr_bus[7] = 1'b1; rd_bus[2] = 13; rd_wr_bus[2] = 1'b1; tick();
    idle(); rs1_idx = 13; push("x13_wrap_window", 1, sal(7, 0, 0)); tick();

    idle(); disp(12, 2); tick();
    idle(); disp(12, 5); tick();
    idle(); flush = 1'b1; rob_front_tag = 2; flush_tag = 4;
    commit(2, 12, 32'hC2); rd_bus[5] = 12; rd_wr_bus[5] = 1'b1; tick();
    idle(); rs2_idx = 12; push("x12_commit_not_survivor", 2, sal(0, 1, 32'hC2)); tick();

    idle(); disp(3, 2); tick();
    idle(); rs1_idx = 3; rob_broadcast_bus[2] = sal(2, 1, 32'h55);
`ifdef BYPASS_EN
    push("x3_bypass", 1, sal(2, 1, 32'h55));
`else
    push("x3_no_bypass", 1, sal(2, 0, 0));
`endif
    tick();
    idle(); rs1_idx = 3; rob_broadcast_bus[2] = sal(2, 0, 32'h55);
    push("x3_bcast_not_ready", 1, sal(2, 0, 0)); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
